// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encoding, FSM states and datapath constants.
package ex_muldiv_ctrl_pkg;

   localparam int XLEN         = 32;
   localparam int MULDIV_STEPS = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with single-cycle divide shortcuts.
module ex_muldiv_ctrl
   import ex_muldiv_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] read_data_1,
   input  logic [XLEN-1:0] read_data_2,
   input  logic            flush,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [5:0] LAST_STEP = 6'(MULDIV_STEPS - 1);

   muldiv_state_e   state;
   muldiv_op_e      op_q;
   logic [5:0]      cnt;
   logic [XLEN-1:0] opnd;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] result_q;
   logic            neg_a;
   logic            neg_ab;

   muldiv_op_e      op_in;
   logic            sign_a, sign_b, neg_a_in, neg_b_in, is_div_in;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b, short_res;

   logic [XLEN:0]   sum, shifted, diff;
   logic [XLEN-1:0] hi_nxt, lo_nxt;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0] quo_fix, rem_fix, final_res;

   // Operand decode and the two divide cases that skip the iteration.
   always_comb begin
      op_in     = muldiv_op_e'(op);
      is_div_in = op[2];
      sign_a    = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      sign_b    = op_in inside {OP_MULH, OP_DIV, OP_REM};
      neg_a_in  = sign_a & read_data_1[XLEN-1];
      neg_b_in  = sign_b & read_data_2[XLEN-1];
      mag_a     = negate_if(neg_a_in, read_data_1);
      mag_b     = negate_if(neg_b_in, read_data_2);
      div_zero  = is_div_in && (read_data_2 == '0);
      div_ovf   = (op_in inside {OP_DIV, OP_REM}) &&
                  (read_data_1 == 32'h8000_0000) && (read_data_2 == '1);
      short_res = '0;
      if (div_zero)
         short_res = op[1] ? read_data_1 : '1;
      else if (div_ovf)
         short_res = op[1] ? '0 : 32'h8000_0000;
   end

   // hi/lo hold {product high, multiplier/product low} or {remainder, dividend/quotient}.
   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, opnd};
      if (op_q[2]) begin
         if (!diff[XLEN]) begin
            hi_nxt = diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = shifted[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_nxt = sum[XLEN:1];
         lo_nxt = {sum[0], lo[XLEN-1:1]};
      end
   end

   always_comb begin
      prod     = {hi_nxt, lo_nxt};
      prod_fix = neg_ab ? -prod : prod;
      quo_fix  = negate_if(neg_ab, lo_nxt);
      rem_fix  = negate_if(neg_a, hi_nxt);
      case (op_q)
         OP_MUL:                      final_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             final_res = quo_fix;
         default:                     final_res = rem_fix;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and also clears the datapath registers so no stale operand survives an abort.
      if (rst) begin
         state    <= ST_IDLE;
         op_q     <= OP_MUL;
         cnt      <= '0;
         opnd     <= '0;
         hi       <= '0;
         lo       <= '0;
         result_q <= '0;
         neg_a    <= 1'b0;
         neg_ab   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !flush) begin
                  op_q   <= op_in;
                  neg_a  <= neg_a_in;
                  neg_ab <= neg_a_in ^ neg_b_in;
                  cnt    <= '0;
                  hi     <= '0;
                  if (div_zero || div_ovf) begin
                     result_q <= short_res;
                     state    <= ST_DONE;
                  end else begin
                     opnd  <= is_div_in ? mag_b : mag_a;
                     lo    <= is_div_in ? mag_a : mag_b;
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else begin
                  hi  <= hi_nxt;
                  lo  <= lo_nxt;
                  cnt <= cnt + 6'd1;
                  if (cnt == LAST_STEP) begin
                     result_q <= final_res;
                     state    <= ST_DONE;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign stall  = ((state == ST_IDLE) && start) || (state == ST_RUN);
   assign done   = (state == ST_DONE);
   assign result = result_q;

endmodule
